nf10_dst_port_demux: RTL and testbench

- Sits downstream of the router output-port lookup and consumes the destination-port bitmap that stage writes into TUSER.
- Fans one 256-bit AXI4-Stream input out to NUM_PORTS master streams, one per MAC or CPU DMA queue.
- Multicast-capable: a packet is delivered to every port whose dst bit is set. A zero bitmap drops the packet.
- Protocol-correct per-port handshake. Per-port packet counters and a drop counter are exported as status.

---
 rtl/nf10_demux_pkg.sv | 15 +
 rtl/nf10_demux_port_slice.sv | 129 ++++++++++++
 rtl/nf10_dst_port_demux.sv | 135 +++++++++++++
 tb/tb_nf10_dst_port_demux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_demux_pkg.sv
// Shared definitions for the NetFPGA-10G destination-port demultiplexer:
// FSM encodings, bitmap geometry and status counter width.
package nf10_demux_pkg;

   typedef enum logic [1:0] {
      HEADER    = 2'd0,
      IN_PACKET = 2'd1,
      DROP      = 2'd2
   } demux_state_e;

   localparam int DST_PORT_POS_DEFAULT = 24;
   localparam int BITMAP_W             = 8;
   localparam int CNT_W                = 32;

endpackage

// File: rtl/nf10_demux_port_slice.sv
// One output lane of the demux: handshake tracking, optional output register
// (enabled by DST_DEMUX_OUTPUT_REG_EN) and the per-port packet counter.
module nf10_demux_port_slice
   import nf10_demux_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int USER_W = 128
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sel_i,
   input  logic                valid_i,
   input  logic                beatDone_i,
   input  logic [DATA_W-1:0]   tdata_i,
   input  logic [DATA_W/8-1:0] tstrb_i,
   input  logic [USER_W-1:0]   tuser_i,
   input  logic                tlast_i,
   input  logic                mReady_i,
   output logic                mValid_o,
   output logic                portReady_o,
   output logic [DATA_W-1:0]   tdata_o,
   output logic [DATA_W/8-1:0] tstrb_o,
   output logic [USER_W-1:0]   tuser_o,
   output logic                tlast_o,
   output logic [CNT_W-1:0]    pktCount_o
);

   logic [CNT_W-1:0] pktCount_q;
   logic [CNT_W-1:0] pktCount_d;

   always_comb begin
      pktCount_d = pktCount_q;
      if (beatDone_i && tlast_i && sel_i) begin
         pktCount_d = pktCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pktCount_q <= '0;
      end else begin
         pktCount_q <= pktCount_d;
      end
   end

   assign pktCount_o = pktCount_q;

`ifdef DST_DEMUX_OUTPUT_REG_EN

   // One-entry skid: a new beat may load whenever the entry is empty or
   // being drained this cycle.
   logic                regValid_q;
   logic                regValid_d;
   logic [DATA_W-1:0]   regData_q;
   logic [DATA_W/8-1:0] regStrb_q;
   logic [USER_W-1:0]   regUser_q;
   logic                regLast_q;
   logic                load;

   assign load        = valid_i & beatDone_i & sel_i;
   assign portReady_o = ~sel_i | ~regValid_q | mReady_i;

   always_comb begin
      regValid_d = regValid_q;
      if (load) begin
         regValid_d = 1'b1;
      end else if (mReady_i) begin
         regValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         regValid_q <= 1'b0;
      end else begin
         regValid_q <= regValid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (load) begin
         regData_q <= tdata_i;
         regStrb_q <= tstrb_i;
         regUser_q <= tuser_i;
         regLast_q <= tlast_i;
      end
   end

   assign mValid_o = regValid_q;
   assign tdata_o  = regData_q;
   assign tstrb_o  = regStrb_q;
   assign tuser_o  = regUser_q;
   assign tlast_o  = regLast_q;

`else

   // done remembers that this port already took the current beat while a
   // sibling port is still stalling the input.
   logic done_q;
   logic done_d;

   assign mValid_o    = ~rst_i & valid_i & sel_i & ~done_q;
   assign portReady_o = ~sel_i | done_q | mReady_i;

   always_comb begin
      done_d = done_q;
      if (beatDone_i) begin
         done_d = 1'b0;
      end else if (sel_i && mValid_o && mReady_i) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign tdata_o = tdata_i;
   assign tstrb_o = tstrb_i;
   assign tuser_o = tuser_i;
   assign tlast_o = tlast_i;

`endif

endmodule

// File: rtl/nf10_dst_port_demux.sv
// Multicast AXI4-Stream demux steered by the destination bitmap in TUSER.
// Define DST_DEMUX_OUTPUT_REG_EN for a registered (1-cycle) output stage.
module nf10_dst_port_demux
   import nf10_demux_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_PORTS            = 8,
   parameter int DST_PORT_POS         = DST_PORT_POS_DEFAULT
)(
   input  logic                                        AXI_ACLK,
   input  logic                                        AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]              S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]            S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]             S_AXIS_TUSER,
   input  logic                                        S_AXIS_TVALID,
   output logic                                        S_AXIS_TREADY,
   input  logic                                        S_AXIS_TLAST,
   output logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [NUM_PORTS*C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic [NUM_PORTS-1:0]                        M_AXIS_TVALID,
   input  logic [NUM_PORTS-1:0]                        M_AXIS_TREADY,
   output logic [NUM_PORTS-1:0]                        M_AXIS_TLAST,
   output logic [NUM_PORTS*CNT_W-1:0]                  PKT_COUNT,
   output logic [CNT_W-1:0]                            DROP_COUNT
);

   demux_state_e         state_q;
   demux_state_e         state_d;
   logic [NUM_PORTS-1:0] sel_q;
   logic [NUM_PORTS-1:0] sel_d;
   logic [CNT_W-1:0]     dropCount_q;
   logic [CNT_W-1:0]     dropCount_d;

   logic [BITMAP_W-1:0]  bitmapRaw;
   logic [NUM_PORTS-1:0] bitmap;
   logic [NUM_PORTS-1:0] effSel;
   logic [NUM_PORTS-1:0] portReady;
   logic                 beatDone;

   // Bitmap bits beyond the implemented port count are ignored.
   assign bitmapRaw = S_AXIS_TUSER[DST_PORT_POS +: BITMAP_W];
   assign bitmap    = bitmapRaw[NUM_PORTS-1:0];

   always_comb begin
      effSel = '0;
      case (state_q)
         HEADER:    effSel = bitmap;
         IN_PACKET: effSel = sel_q;
         default:   effSel = '0;
      endcase
   end

   assign S_AXIS_TREADY = ~AXI_RESET & (&portReady);
   assign beatDone      = S_AXIS_TVALID & S_AXIS_TREADY;

   // Header decides delivery vs. drop; the selection is frozen for the rest
   // of the packet so mid-packet TUSER changes have no effect.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      dropCount_d = dropCount_q;
      case (state_q)
         HEADER: begin
            if (beatDone) begin
               if (bitmap == '0) begin
                  dropCount_d = dropCount_q + CNT_W'(1);
                  if (!S_AXIS_TLAST) begin
                     state_d = DROP;
                  end
               end else if (!S_AXIS_TLAST) begin
                  state_d = IN_PACKET;
                  sel_d   = bitmap;
               end
            end
         end
         IN_PACKET: begin
            if (beatDone && S_AXIS_TLAST) begin
               state_d = HEADER;
            end
         end
         DROP: begin
            if (beatDone && S_AXIS_TLAST) begin
               state_d = HEADER;
            end
         end
         default: begin
            state_d = HEADER;
         end
      endcase
   end

   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         state_q     <= HEADER;
         sel_q       <= '0;
         dropCount_q <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         dropCount_q <= dropCount_d;
      end
   end

   assign DROP_COUNT = dropCount_q;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      nf10_demux_port_slice #(
         .DATA_W (C_M_AXIS_DATA_WIDTH),
         .USER_W (C_M_AXIS_TUSER_WIDTH)
      ) u_slice (
         .clk_i       (AXI_ACLK),
         .rst_i       (AXI_RESET),
         .sel_i       (effSel[i]),
         .valid_i     (S_AXIS_TVALID),
         .beatDone_i  (beatDone),
         .tdata_i     (S_AXIS_TDATA),
         .tstrb_i     (S_AXIS_TSTRB),
         .tuser_i     (S_AXIS_TUSER),
         .tlast_i     (S_AXIS_TLAST),
         .mReady_i    (M_AXIS_TREADY[i]),
         .mValid_o    (M_AXIS_TVALID[i]),
         .portReady_o (portReady[i]),
         .tdata_o     (M_AXIS_TDATA[i*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH]),
         .tstrb_o     (M_AXIS_TSTRB[i*(C_M_AXIS_DATA_WIDTH/8) +: C_M_AXIS_DATA_WIDTH/8]),
         .tuser_o     (M_AXIS_TUSER[i*C_M_AXIS_TUSER_WIDTH +: C_M_AXIS_TUSER_WIDTH]),
         .tlast_o     (M_AXIS_TLAST[i]),
         .pktCount_o  (PKT_COUNT[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_nf10_dst_port_demux.sv
// Directed bench for nf10_dst_port_demux (default build, zero-latency path)
// with a per-port expected-beat scoreboard.
module tb_nf10_dst_port_demux;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int NP = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic              clk;
   logic              rst;
   logic [DW-1:0]     sTdata;
   logic [DW/8-1:0]   sTstrb;
   logic [UW-1:0]     sTuser;
   logic              sTvalid;
   logic              sTready;
   logic              sTlast;
   logic [NP*DW-1:0]  mTdata;
   logic [NP*DW/8-1:0] mTstrb;
   logic [NP*UW-1:0]  mTuser;
   logic [NP-1:0]     mTvalid;
   logic [NP-1:0]     mTready;
   logic [NP-1:0]     mTlast;
   logic [NP*32-1:0]  pktCount;
   logic [31:0]       dropCount;

   int total = 0;
   int bad   = 0;

   beat_t sbQ[NP][$];

   nf10_dst_port_demux #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .NUM_PORTS            (NP),
      .DST_PORT_POS         (24)
   ) dut (
      .AXI_ACLK      (clk),
      .AXI_RESET     (rst),
      .S_AXIS_TDATA  (sTdata),
      .S_AXIS_TSTRB  (sTstrb),
      .S_AXIS_TUSER  (sTuser),
      .S_AXIS_TVALID (sTvalid),
      .S_AXIS_TREADY (sTready),
      .S_AXIS_TLAST  (sTlast),
      .M_AXIS_TDATA  (mTdata),
      .M_AXIS_TSTRB  (mTstrb),
      .M_AXIS_TUSER  (mTuser),
      .M_AXIS_TVALID (mTvalid),
      .M_AXIS_TREADY (mTready),
      .M_AXIS_TLAST  (mTlast),
      .PKT_COUNT     (pktCount),
      .DROP_COUNT    (dropCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one beat at posedge+1 and records which ports must receive it.
   task automatic applyStimulus(input logic [7:0] bm, input logic last, input logic [NP-1:0] expSel);
      beat_t e;
      for (int w = 0; w < DW/32; w++) sTdata[w*32 +: 32] = $urandom();
      sTuser          = '0;
      sTuser[24 +: 8] = bm;
      sTuser[127:96]  = $urandom();
      sTstrb          = '1;
      sTlast          = last;
      sTvalid         = 1'b1;
      e.data = sTdata;
      e.last = last;
      for (int p = 0; p < NP; p++) if (expSel[p]) sbQ[p].push_back(e);
   endtask

   // Called at a negedge; returns at posedge+1 after the beat is taken.
   task automatic waitAccept(input string tag);
      int n = 0;
      while (!sTready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!sTready) begin
         total++;
         bad++;
         $display("FAIL %s: observed=no handshake expected=accept within 100 cycles", tag);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sendBeat(input string tag, input logic [7:0] bm, input logic last, input logic [NP-1:0] expSel);
      applyStimulus(bm, last, expSel);
      @(negedge clk);
      waitAccept(tag);
   endtask

   task automatic idle();
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every accepted output beat must match the scoreboard.
   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (mTvalid[p] && mTready[p]) begin
            if (sbQ[p].size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpectedBeat port%0d: observed=valid beat expected=no beat", p);
            end else begin
               beat_t e;
               e = sbQ[p].pop_front();
               checkOutput($sformatf("port%0dData", p), mTdata[p*DW +: DW], e.data);
               checkOutput($sformatf("port%0dLast", p), {255'd0, mTlast[p]}, {255'd0, e.last});
            end
         end
      end
   end

   initial begin
      rst     = 1'b1;
      sTdata  = '0;
      sTstrb  = '0;
      sTuser  = '0;
      sTuser[24 +: 8] = 8'hFF;
      sTvalid = 1'b1;
      sTlast  = 1'b0;
      mTready = '1;

      // Reset state with a live valid header on the input
      #12;
      checkOutput("rstValid", {248'd0, mTvalid}, '0);
      checkOutput("rstReady", {255'd0, sTready}, '0);
      checkOutput("rstPktCnt", pktCount, '0);
      checkOutput("rstDropCnt", {224'd0, dropCount}, '0);
      sTvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 3-beat unicast to port 2
      applyStimulus(8'h04, 1'b0, 8'h04);
      @(negedge clk);
      checkOutput("uniValid", {248'd0, mTvalid}, {248'd0, 8'h04});
      waitAccept("uniB0");
      sendBeat("uniB1", 8'h04, 1'b0, 8'h04);
      sendBeat("uniB2", 8'h04, 1'b1, 8'h04);
      idle();
      checkOutput("uniPkt2", {224'd0, pktCount[2*32 +: 32]}, {224'd0, 32'd1});

      // Multicast 0x05 with port 2 stalled on the first beat
      mTready = 8'hFB;
      applyStimulus(8'h05, 1'b0, 8'h05);
      @(negedge clk);
      checkOutput("stallV0First", {255'd0, mTvalid[0]}, {255'd0, 1'b1});
      checkOutput("stallReady0", {255'd0, sTready}, '0);
      @(negedge clk);
      checkOutput("stallV0Done", {255'd0, mTvalid[0]}, '0);
      checkOutput("stallV2Held", {255'd0, mTvalid[2]}, {255'd0, 1'b1});
      checkOutput("stallReady1", {255'd0, sTready}, '0);
      repeat (2) @(posedge clk);
      #1;
      mTready = '1;
      @(negedge clk);
      waitAccept("mcB0");
      sendBeat("mcB1", 8'h05, 1'b0, 8'h05);
      sendBeat("mcB2", 8'h05, 1'b1, 8'h05);
      idle();
      checkOutput("mcPkt0", {224'd0, pktCount[0*32 +: 32]}, {224'd0, 32'd1});
      checkOutput("mcPkt2", {224'd0, pktCount[2*32 +: 32]}, {224'd0, 32'd2});

      // Empty bitmap: 2-beat packet dropped, then a normal packet to port 4
      applyStimulus(8'h00, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("dropReady0", {255'd0, sTready}, {255'd0, 1'b1});
      checkOutput("dropValid0", {248'd0, mTvalid}, '0);
      waitAccept("dropB0");
      applyStimulus(8'h00, 1'b1, 8'h00);
      @(negedge clk);
      checkOutput("dropReady1", {255'd0, sTready}, {255'd0, 1'b1});
      checkOutput("dropValid1", {248'd0, mTvalid}, '0);
      waitAccept("dropB1");
      idle();
      checkOutput("dropCnt", {224'd0, dropCount}, {224'd0, 32'd1});
      sendBeat("p4B0", 8'h10, 1'b0, 8'h10);
      sendBeat("p4B1", 8'h10, 1'b1, 8'h10);
      idle();
      checkOutput("p4Pkt", {224'd0, pktCount[4*32 +: 32]}, {224'd0, 32'd1});

      // TUSER changes mid-packet are ignored
      sendBeat("tuB0", 8'h01, 1'b0, 8'h01);
      sendBeat("tuB1", 8'h80, 1'b1, 8'h01);
      idle();
      checkOutput("tuPkt0", {224'd0, pktCount[0*32 +: 32]}, {224'd0, 32'd2});
      checkOutput("tuPkt7", {224'd0, pktCount[7*32 +: 32]}, '0);

      // Reset asserted mid-packet
      sendBeat("rsB0", 8'h02, 1'b0, 8'h02);
      mTready = '0;
      applyStimulus(8'h02, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("rsPreValid", {255'd0, mTvalid[1]}, {255'd0, 1'b1});
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rsValid", {248'd0, mTvalid}, '0);
      checkOutput("rsReady", {255'd0, sTready}, '0);
      checkOutput("rsPktCnt", pktCount, '0);
      checkOutput("rsDropCnt", {224'd0, dropCount}, '0);
      @(posedge clk);
      #1;
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      mTready = '1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      sendBeat("rsN0", 8'h08, 1'b0, 8'h08);
      sendBeat("rsN1", 8'h08, 1'b1, 8'h08);
      idle();
      checkOutput("rsPkt3", {224'd0, pktCount[3*32 +: 32]}, {224'd0, 32'd1});
      checkOutput("rsPkt1", {224'd0, pktCount[1*32 +: 32]}, '0);

      // Counter wrap on port 1 with a single-beat packet
      force dut.g_port[1].u_slice.pktCount_q = 32'hFFFF_FFFF;
      #1;
      release dut.g_port[1].u_slice.pktCount_q;
      checkOutput("wrapPre", {224'd0, pktCount[1*32 +: 32]}, {224'd0, 32'hFFFF_FFFF});
      @(posedge clk);
      #1;
      sendBeat("wrapB0", 8'h02, 1'b1, 8'h02);
      idle();
      checkOutput("wrapPkt1", {224'd0, pktCount[1*32 +: 32]}, '0);

      // Single-beat drop stays in HEADER; next single-beat goes to port 5
      sendBeat("sdB0", 8'h00, 1'b1, 8'h00);
      sendBeat("sdNext", 8'h20, 1'b1, 8'h20);
      idle();
      checkOutput("sdDropCnt", {224'd0, dropCount}, {224'd0, 32'd1});
      checkOutput("sdPkt5", {224'd0, pktCount[5*32 +: 32]}, {224'd0, 32'd1});

      repeat (2) @(posedge clk);
      for (int p = 0; p < NP; p++) begin
         checkOutput($sformatf("sbEmpty%0d", p), DW'(sbQ[p].size()), '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
